// File: rtl/ecc_point_unit_if.sv
// Request/response bundle between the scalar-multiply controller and ecc_point_unit.
interface ecc_point_unit_if;
   logic       i_start;
   logic       i_dbl;
   logic [3:0] a;
   logic [3:0] prime;
   logic [3:0] x1;
   logic [3:0] y1;
   logic       inf1;
   logic [3:0] x2;
   logic [3:0] y2;
   logic       inf2;
   logic [3:0] x3;
   logic [3:0] y3;
   logic       inf3;
   logic       o_err;
   logic       busy;
   logic       done;

   modport master (
      output i_start, i_dbl, a, prime, x1, y1, inf1, x2, y2, inf2,
      input  x3, y3, inf3, o_err, busy, done
   );

   modport slave (
      input  i_start, i_dbl, a, prime, x1, y1, inf1, x2, y2, inf2,
      output x3, y3, inf3, o_err, busy, done
   );
endinterface

// File: rtl/ecc_point_unit.sv
// Sequential EC point add/double over GF(p), 4-bit elements, inverse by candidate search.
// Define ECC_POINT_AUTO_DBL_EN to turn an add of P with itself into a doubling.
module ecc_point_unit (
   input logic             i_clk,
   input logic             i_rst,
   ecc_point_unit_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StSetup, StInv, StLam, StX3, StY3, StHold, StDone
   } state_e;

   state_e     state_q;
   logic [3:0] p_q, a_q, x1_q, y1_q, x2_q, y2_q;
   logic       dbl_q, inf1_q, inf2_q;
   logic [3:0] num_q, den_q, t_q, lam_q, rx_q;
   logic [3:0] x3_q, y3_q;
   logic       inf3_q, err_q, busy_q, done_q;

   function automatic logic [3:0] mod_mul(input logic [3:0] u, input logic [3:0] v,
                                          input logic [3:0] p);
      logic [7:0] prod;
      prod = {4'd0, u} * {4'd0, v};
      return 4'(prod % {4'd0, p});
   endfunction

   function automatic logic [3:0] mod_add(input logic [3:0] u, input logic [3:0] v,
                                          input logic [3:0] p);
      logic [4:0] s;
      s = {1'b0, u} + {1'b0, v};
      return 4'(s % {1'b0, p});
   endfunction

   // Operands are below p, so u + p - v never underflows.
   function automatic logic [3:0] mod_sub(input logic [3:0] u, input logic [3:0] v,
                                          input logic [3:0] p);
      logic [4:0] s;
      s = {1'b0, u} + {1'b0, p} - {1'b0, v};
      return 4'(s % {1'b0, p});
   endfunction

   logic [3:0] dbl_num, dbl_den, add_num, add_den, prod_dt, x3_new, y3_new;
   logic       auto_dbl;

   always_comb begin
      dbl_num = mod_add(mod_mul(4'd3, mod_mul(x1_q, x1_q, p_q), p_q), a_q, p_q);
      dbl_den = mod_add(y1_q, y1_q, p_q);
      add_num = mod_sub(y2_q, y1_q, p_q);
      add_den = mod_sub(x2_q, x1_q, p_q);
      prod_dt = mod_mul(den_q, t_q, p_q);
      x3_new  = mod_sub(mod_sub(mod_mul(lam_q, lam_q, p_q), x1_q, p_q),
                        dbl_q ? x1_q : x2_q, p_q);
      y3_new  = mod_sub(mod_mul(lam_q, mod_sub(x1_q, rx_q, p_q), p_q), y1_q, p_q);
   end

`ifdef ECC_POINT_AUTO_DBL_EN
   assign auto_dbl = (x1_q == x2_q) && (y1_q == y2_q) && (y1_q != 4'd0);
`else
   assign auto_dbl = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= StIdle;
         p_q     <= 4'd0;
         a_q     <= 4'd0;
         x1_q    <= 4'd0;
         y1_q    <= 4'd0;
         x2_q    <= 4'd0;
         y2_q    <= 4'd0;
         dbl_q   <= 1'b0;
         inf1_q  <= 1'b0;
         inf2_q  <= 1'b0;
         num_q   <= 4'd0;
         den_q   <= 4'd0;
         t_q     <= 4'd0;
         lam_q   <= 4'd0;
         rx_q    <= 4'd0;
         x3_q    <= 4'd0;
         y3_q    <= 4'd0;
         inf3_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.i_start) begin
                  p_q     <= bus.prime;
                  a_q     <= bus.a;
                  x1_q    <= bus.x1;
                  y1_q    <= bus.y1;
                  x2_q    <= bus.x2;
                  y2_q    <= bus.y2;
                  dbl_q   <= bus.i_dbl;
                  inf1_q  <= bus.inf1;
                  inf2_q  <= bus.inf2;
                  inf3_q  <= 1'b0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               t_q <= 4'd1;
               if (inf1_q) begin
                  x3_q    <= dbl_q ? 4'd0 : x2_q;
                  y3_q    <= dbl_q ? 4'd0 : y2_q;
                  inf3_q  <= dbl_q | inf2_q;
                  state_q <= StHold;
               end else if (!dbl_q && inf2_q) begin
                  x3_q    <= x1_q;
                  y3_q    <= y1_q;
                  inf3_q  <= 1'b0;
                  state_q <= StHold;
               end else if ((dbl_q && y1_q == 4'd0) ||
                            (!dbl_q && x1_q == x2_q && !auto_dbl)) begin
                  x3_q    <= 4'd0;
                  y3_q    <= 4'd0;
                  inf3_q  <= 1'b1;
                  state_q <= StHold;
               end else if (dbl_q || auto_dbl) begin
                  dbl_q   <= 1'b1;
                  num_q   <= dbl_num;
                  den_q   <= dbl_den;
                  state_q <= StInv;
               end else begin
                  num_q   <= add_num;
                  den_q   <= add_den;
                  state_q <= StInv;
               end
            end
            StInv: begin
               if (t_q == p_q) begin
                  x3_q    <= 4'd0;
                  y3_q    <= 4'd0;
                  inf3_q  <= 1'b1;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else if (prod_dt == 4'd1) begin
                  state_q <= StLam;  // t_q now holds the inverse
               end else begin
                  t_q <= t_q + 4'd1;
               end
            end
            StLam: begin
               lam_q   <= mod_mul(num_q, t_q, p_q);
               state_q <= StX3;
            end
            StX3: begin
               rx_q    <= x3_new;
               state_q <= StY3;
            end
            StY3: begin
               x3_q    <= rx_q;
               y3_q    <= y3_new;
               inf3_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StHold: begin
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.x3    = x3_q;
   assign bus.y3    = y3_q;
   assign bus.inf3  = inf3_q;
   assign bus.o_err = err_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_ecc_point_unit.sv
// Self-checking bench for ecc_point_unit: directed cases plus random operations vs a math model.
module tb_ecc_point_unit;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ecc_point_unit_if bus ();

   ecc_point_unit dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp))
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int md(input int v, input int p);
      return ((v % p) + p) % p;
   endfunction

   // Curve arithmetic straight from the group law; latency in edges after the start edge.
   function automatic void model(input int p, input int aa, input int px, input int py,
                                 input int pi, input int qx, input int qy, input int qi,
                                 input int d, output int ex, output int ey, output int einf,
                                 output int eerr, output int elat);
      int num, den, inv, lam, xq;
      bit do_dbl, auto;
      ex = 0; ey = 0; einf = 0; eerr = 0; elat = 2; inv = 0;
      num = 0; den = 0; xq = 0;
      do_dbl = (d != 0);
      if (pi != 0) begin
         einf = (d != 0) ? 1 : qi; ex = qx; ey = qy;
         return;
      end
      if (d == 0 && qi != 0) begin
         ex = px; ey = py;
         return;
      end
      if (d != 0 && py == 0) begin
         einf = 1;
         return;
      end
      if (d == 0 && px == qx) begin
         auto = 1'b0;
`ifdef ECC_POINT_AUTO_DBL_EN
         auto = (py == qy) && (py != 0);
`endif
         if (!auto) begin
            einf = 1;
            return;
         end
         do_dbl = 1'b1;
      end
      if (do_dbl) begin
         num = md(3 * px * px + aa, p); den = md(2 * py, p); xq = px;
      end else begin
         num = md(qy - py, p); den = md(qx - px, p); xq = qx;
      end
      for (int t = 1; t < p; t++)
         if (inv == 0 && md(den * t, p) == 1) inv = t;
      if (inv == 0) begin
         einf = 1; eerr = 1; elat = p + 1;
         return;
      end
      lam  = md(num * inv, p);
      ex   = md(lam * lam - px - xq, p);
      ey   = md(lam * (px - ex) - py, p);
      elat = 4 + inv;
   endfunction

   task automatic run_op(input string name, input int p, input int aa, input int px,
                         input int py, input int pi, input int qx, input int qy,
                         input int qi, input int d, input int hold);
      int ex, ey, einf, eerr, elat, n;
      model(p, aa, px, py, pi, qx, qy, qi, d, ex, ey, einf, eerr, elat);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_dbl   = 1'(d);
      bus.prime   = 4'(p);
      bus.a       = 4'(aa);
      bus.x1      = 4'(px);
      bus.y1      = 4'(py);
      bus.inf1    = 1'(pi);
      bus.x2      = 4'(qx);
      bus.y2      = 4'(qy);
      bus.inf2    = 1'(qi);
      @(posedge clk);
      n = 0;
      @(negedge clk);
      check({name, ".busy"}, 32'(bus.busy), 1);
      // Start stays high for a few edges while busy; it must be ignored.
      while (bus.done !== 1'b1 && n < 40) begin
         if (n + 1 >= hold) bus.i_start = 1'b0;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      bus.i_start = 1'b0;
      check({name, ".latency"}, 32'(n), elat);
      check({name, ".inf3"}, 32'(bus.inf3), einf);
      check({name, ".err"}, 32'(bus.o_err), eerr);
      if (einf == 0) begin
         check({name, ".x3"}, 32'(bus.x3), ex);
         check({name, ".y3"}, 32'(bus.y3), ey);
      end
      @(negedge clk);
      check({name, ".done_drop"}, 32'(bus.done), 0);
      check({name, ".idle"}, 32'(bus.busy), 0);
   endtask

   initial begin
      int p, aa, px, py, pi, qx, qy, qi, d, cnt;
      rst = 1'b0;
      bus.i_start = 1'b0; bus.i_dbl = 1'b0; bus.a = 4'd0; bus.prime = 4'd11;
      bus.x1 = 4'd0; bus.y1 = 4'd0; bus.inf1 = 1'b0;
      bus.x2 = 4'd0; bus.y2 = 4'd0; bus.inf2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.x3", 32'(bus.x3), 0);
      check("reset.y3", 32'(bus.y3), 0);
      check("reset.inf3", 32'(bus.inf3), 0);
      check("reset.err", 32'(bus.o_err), 0);
      check("reset.busy", 32'(bus.busy), 0);
      check("reset.done", 32'(bus.done), 0);
      rst = 1'b1;

      run_op("dbl", 11, 1, 0, 1, 0, 0, 0, 0, 1, 3);
      run_op("add", 11, 1, 0, 1, 0, 3, 3, 0, 0, 3);
      run_op("neg", 11, 1, 0, 1, 0, 0, 10, 0, 0, 1);
      run_op("inf1", 11, 1, 0, 1, 1, 3, 3, 0, 0, 3);
      run_op("same", 11, 1, 0, 1, 0, 0, 1, 0, 0, 1);
      run_op("noinv", 15, 1, 0, 3, 0, 0, 0, 0, 1, 1);
      run_op("dbl2", 11, 1, 0, 1, 0, 0, 0, 0, 1, 1);

      // Abort a double with reset sampled on E3.
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_dbl = 1'b1; bus.prime = 4'd11; bus.a = 4'd1;
      bus.x1 = 4'd0; bus.y1 = 4'd1; bus.inf1 = 1'b0; bus.inf2 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort.x3", 32'(bus.x3), 0);
      check("abort.y3", 32'(bus.y3), 0);
      check("abort.inf3", 32'(bus.inf3), 0);
      check("abort.err", 32'(bus.o_err), 0);
      check("abort.busy", 32'(bus.busy), 0);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) cnt++;
      end
      check("abort.nodone", 32'(cnt), 0);
      run_op("after_abort", 11, 1, 0, 1, 0, 0, 0, 0, 1, 1);

      for (int i = 0; i < 40; i++) begin
         p  = int'($urandom_range(3, 15));
         aa = int'($urandom_range(0, p - 1));
         px = int'($urandom_range(0, p - 1));
         py = int'($urandom_range(0, p - 1));
         qx = int'($urandom_range(0, p - 1));
         qy = int'($urandom_range(0, p - 1));
         d  = int'($urandom_range(0, 1));
         pi = ($urandom_range(0, 9) == 0) ? 1 : 0;
         qi = (d == 0 && $urandom_range(0, 9) == 0) ? 1 : 0;
         if ($urandom_range(0, 3) == 0) qx = px;
         if ($urandom_range(0, 3) == 0) qy = py;
         run_op("rand", p, aa, px, py, pi, qx, qy, qi, d, int'($urandom_range(1, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
